// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets two req/ack masters share one synchronous RAM, and blocks writes at or above ROM_BASE.
// Latency: a request granted at edge E is issued in cycle E+1 and acked in E+2. Backpressure: a master holds req until its ack.
module mem_arbiter #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(8'h80)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_el0;
    logic                w_el1;
    logic                w_grant;
    logic                w_win;
    logic                w_blocked;
    logic                w_complete;
    logic                w_rd_done0;
    logic                w_rd_done1;

    // The port being acked this cycle may not win again at the same edge.
    always_comb begin
        w_complete = (r_state == S_COMPLETE);
        w_blocked  = r_we && (r_addr >= ROM_BASE);
        w_el0      = req0 && !(w_complete && (r_owner == 1'b0));
        w_el1      = req1 && !(w_complete && (r_owner == 1'b1));
        w_grant    = ((r_state == S_IDLE) || w_complete) && (w_el0 || w_el1);
        w_win      = (w_el0 && w_el1) ? ~r_last : w_el1;
        w_rd_done0 = w_complete && (r_owner == 1'b0) && !r_we;
        w_rd_done1 = w_complete && (r_owner == 1'b1) && !r_we;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_COMPLETE;
            end
            S_COMPLETE: begin
                w_state_nxt = w_grant ? S_ISSUE : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_win;
                r_last  <= w_win;
                r_we    <= w_win ? we1    : we0;
                r_addr  <= w_win ? addr1  : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
            end
            if (w_rd_done0) begin
                r_rdata0 <= ram_rdata;
            end
            if (w_rd_done1) begin
                r_rdata1 <= ram_rdata;
            end
        end
    end

    // Command registers only change on a grant, so the RAM bus holds between accesses.
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_we    = (r_state == S_ISSUE) && r_we && !w_blocked;
    assign busy      = (r_state != S_IDLE);

    assign ack0   = w_complete && (r_owner == 1'b0);
    assign ack1   = w_complete && (r_owner == 1'b1);
    assign err0   = ack0 && w_blocked;
    assign err1   = ack1 && w_blocked;
    assign rdata0 = w_rd_done0 ? ram_rdata : r_rdata0;
    assign rdata1 = w_rd_done1 ? ram_rdata : r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: synchronous RAM stub, timestamp-based transaction model compared every cycle, directed literal checks.
module tb_mem_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we, busy;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .ROM_BASE(8'h80)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM stub and the model's own copy of memory, preloaded identically
    logic [7:0] ram   [256];
    logic [7:0] m_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]   = 8'(i) ^ 8'h5A;
            m_mem[i] = 8'(i) ^ 8'h5A;
        end
        ram[8'h05] = 8'h3C;  m_mem[8'h05] = 8'h3C;
        ram[8'h80] = 8'hC3;  m_mem[8'h80] = 8'hC3;
        ram_rdata  = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: a grant at edge g means ISSUE after g, COMPLETE after g+1,
    // and the next arbitration at g+2 with the completing port excluded.
    int         n       = 0;
    bit         started = 0;
    bit         pend    = 0;
    int         g_edge  = 0;
    int         owner   = 0;
    int         last    = 1;
    bit         c_we    = 0;
    logic [7:0] c_addr  = 8'h00;
    logic [7:0] c_wd    = 8'h00;
    logic [7:0] m_rd [2] = '{8'h00, 8'h00};
    bit         el0, el1, can;
    int         excl, win;
    bit         e_issue, e_busy, e_we;
    bit         e_ack [2];
    bit         e_err [2];

    always @(posedge clk) begin
        n++;
        if (pend && n == g_edge + 1 && c_we && c_addr < 8'h80) m_mem[c_addr] = c_wd;
        if (reset) begin
            pend = 0;
            last = 1;
            m_rd = '{8'h00, 8'h00};
        end else begin
            excl = (pend && n == g_edge + 2) ? owner : -1;
            can  = !pend || (n == g_edge + 2);
            if (can) begin
                el0 = req0 && excl != 0;
                el1 = req1 && excl != 1;
                if (el0 || el1) begin
                    win    = (el0 && el1) ? 1 - last : (el0 ? 0 : 1);
                    owner  = win;
                    last   = win;
                    c_we   = (win == 0) ? we0    : we1;
                    c_addr = (win == 0) ? addr0  : addr1;
                    c_wd   = (win == 0) ? wdata0 : wdata1;
                    pend   = 1;
                    g_edge = n;
                end else begin
                    pend = 0;
                end
            end
            if (pend && n == g_edge + 1 && !c_we) m_rd[owner] = m_mem[c_addr];
        end
        e_issue  = pend && n == g_edge;
        e_busy   = pend && (n == g_edge || n == g_edge + 1);
        e_we     = e_issue && c_we && c_addr < 8'h80;
        e_ack[0] = pend && n == g_edge + 1 && owner == 0;
        e_ack[1] = pend && n == g_edge + 1 && owner == 1;
        e_err[0] = e_ack[0] && c_we && c_addr >= 8'h80;
        e_err[1] = e_ack[1] && c_we && c_addr >= 8'h80;
        started  = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_busy",   32'(busy),   32'(e_busy));
            chk("m_ram_we", 32'(ram_we), 32'(e_we));
            chk("m_ack0",   32'(ack0),   32'(e_ack[0]));
            chk("m_ack1",   32'(ack1),   32'(e_ack[1]));
            chk("m_err0",   32'(err0),   32'(e_err[0]));
            chk("m_err1",   32'(err1),   32'(e_err[1]));
            chk("m_rdata0", 32'(rdata0), 32'(m_rd[0]));
            chk("m_rdata1", 32'(rdata1), 32'(m_rd[1]));
            if (e_issue) begin
                chk("m_ram_addr", 32'(ram_addr), 32'(c_addr));
                if (c_we) chk("m_ram_wdata", 32'(ram_wdata), 32'(c_wd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        repeat (3) tick();
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_ack",    32'({ack0, ack1, err0, err1}), 32'd0);
        chk("rst_ram_we", 32'(ram_we),    32'd0);
        chk("rst_rdata",  32'({rdata0, rdata1}), 32'd0);
        chk("rst_addr",   32'(ram_addr),  32'd0);
        chk("rst_wdata",  32'(ram_wdata), 32'd0);

        // single read on port 0
        reset = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        tick();
        chk("rd_issue_addr", 32'(ram_addr), 32'h05);
        chk("rd_issue_we",   32'(ram_we),   32'd0);
        chk("rd_issue_busy", 32'(busy),     32'd1);
        chk("rd_issue_ack",  32'(ack0),     32'd0);
        tick();
        chk("rd_ack0",   32'(ack0),   32'd1);
        chk("rd_rdata0", 32'(rdata0), 32'h3C);
        chk("rd_busy",   32'(busy),   32'd1);
        req0 = 1'b0;
        tick();
        chk("rd_idle_busy", 32'(busy),   32'd0);
        chk("rd_hold",      32'(rdata0), 32'h3C);

        // port 1 write then read-back
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 8'hA5;
        tick();
        chk("wr_we_issue", 32'(ram_we), 32'd1);
        tick();
        chk("wr_ack1",   32'(ack1),   32'd1);
        chk("wr_err1",   32'(err1),   32'd0);
        chk("wr_we_off", 32'(ram_we), 32'd0);
        req1 = 1'b0;
        tick();
        req1 = 1'b1; we1 = 1'b0;
        tick();
        tick();
        chk("rb_ack1",   32'(ack1),   32'd1);
        chk("rb_rdata1", 32'(rdata1), 32'hA5);
        req1 = 1'b0;
        tick();

        // write into the protected half
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h80; wdata0 = 8'h77;
        tick();
        chk("rom_we", 32'(ram_we), 32'd0);
        tick();
        chk("rom_ack0", 32'(ack0), 32'd1);
        chk("rom_err0", 32'(err0), 32'd1);
        req0 = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b0;
        tick();
        tick();
        chk("rom_rb_ack0", 32'(ack0),   32'd1);
        chk("rom_rb_data", 32'(rdata0), 32'hC3);
        req0 = 1'b0;
        tick();

        // port 0 holds req across its ack: one IDLE cycle, next ack 3 cycles later
        req0 = 1'b1; addr0 = 8'h05;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("excl_ack0", 32'(ack0), 32'(k == 2 || k == 5));
            chk("excl_busy", 32'(busy), 32'(k != 3));
        end
        req0 = 1'b0;
        tick();

        // request dropped before ack: latched command still completes
        req0 = 1'b1; addr0 = 8'h10;
        tick();
        req0 = 1'b0;
        tick();
        chk("drop_ack0",   32'(ack0),   32'd1);
        chk("drop_rdata0", 32'(rdata0), 32'hA5);
        tick();

        // contention from reset release: 0,1,0,1 with no idle gaps
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("rr_ack0", 32'(ack0), 32'(k % 4 == 2));
            chk("rr_ack1", 32'(ack1), 32'(k % 4 == 0));
            chk("rr_busy", 32'(busy), 32'd1);
            if (k == 4) chk("rr_rdata1", 32'(rdata1), 32'hA5);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        // reset during ISSUE of a port 1 read
        req1 = 1'b1; addr1 = 8'h10;
        tick();
        chk("mid_issue_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_ack1",   32'(ack1),   32'd0);
        chk("mid_busy",   32'(busy),   32'd0);
        chk("mid_we",     32'(ram_we), 32'd0);
        chk("mid_rdata1", 32'(rdata1), 32'd0);
        reset = 1'b0; req0 = 1'b1; addr0 = 8'h05;
        tick();
        tick();
        chk("post_tie_ack0", 32'(ack0), 32'd1);
        chk("post_tie_ack1", 32'(ack1), 32'd0);
        req0 = 1'b0;
        tick();
        chk("post_issue1", 32'(busy), 32'd1);
        tick();
        chk("post_ack1",   32'(ack1),   32'd1);
        chk("post_rdata1", 32'(rdata1), 32'hA5);
        req1 = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
